imem_fetch_ctrl: RTL and testbench

- Fetch sequencer for the synchronous-read instruction memory.
- Owns the program counter and drives the memory address.
- Tracks the one-cycle read latency and buffers fetched words in a small FIFO. The FIFO absorbs decode-stage back-pressure.
- Handles PC redirects (branch/jump/exception) by flushing all in-flight and buffered instructions.
- Sits between instruction_memory and the IF/ID pipeline register.

---
 rtl/imem_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: program-counter sequencer for a synchronous-read
// instruction memory. Issues one read per cycle while credit is available,
// tracks the one-cycle read latency, buffers returned words in a small FIFO
// and flushes everything on a PC redirect.
//
// Decode handshake: fetch_valid/fetch_ready. A word transfers on a cycle
// where fetch_valid && fetch_ready. fetch_valid never depends on
// fetch_ready. While fetch_valid is high the presented {fetch_instr,
// fetch_pc} stays stable until accepted, unless a redirect or reset flushes
// it.
module imem_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [31:0]       fetch_instr,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  // Architectural state.
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       last_instr_q;
  logic [ADDR_W-1:0] last_pc_q;

  // FIFO storage (data only; occupancy lives in count_q).
  logic [31:0]       buf_instr_q [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_q    [BUF_DEPTH];

  logic              have_buf;
  logic              pop;
  logic              pop_buf;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ;

  // The two low bits of a redirect target are dropped by design.
  logic              redirect_lsb_unused;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign imem_addr = req_pc_q;
  assign have_buf  = (count_q != '0);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Output select: FIFO head first, then the in-flight word by bypass,
  // otherwise hold the last presented values.
  always_comb begin
    fetch_valid = !redirect_valid && (have_buf || inflight_q);
    fetch_instr = last_instr_q;
    fetch_pc    = last_pc_q;
    if (have_buf) begin
      fetch_instr = buf_instr_q[rd_ptr_q];
      fetch_pc    = buf_pc_q[rd_ptr_q];
    end else if (inflight_q) begin
      fetch_instr = imem_rdata;
      fetch_pc    = inflight_pc_q;
    end
  end

  // Handshake, buffering and credit-based issue decisions.
  always_comb begin
    pop     = fetch_valid && fetch_ready && !redirect_valid;
    pop_buf = pop && have_buf;
    // An in-flight word is buffered unless the bypass path hands it to
    // decode this cycle; a redirect discards it.
    push    = inflight_q && !redirect_valid && !(pop && !have_buf);
    // Words owned after this edge if nothing new is issued.
    occ     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}
            - {{CNT_W{1'b0}}, pop};
    issue   = fetch_en && !redirect_valid && (occ < OCC_W'(BUF_DEPTH));
  end

  // Next-state for PC, in-flight tracking and FIFO pointers.
  always_comb begin
    req_pc_d      = req_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      req_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = req_pc_q;
        req_pc_d      = req_pc_q + ADDR_W'(4);
      end
      if (push)    wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_buf) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop_buf})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers; reset discards all outstanding and buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q      <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= RESET_PC;
    end else begin
      req_pc_q      <= req_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      last_instr_q  <= fetch_instr;
      last_pc_q     <= fetch_pc;
    end
  end

  // FIFO data write at the tail; contents are qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: synchronous memory model, program-order
// scoreboard and one task per scenario.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // Clock / reset and DUT signals.
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected upcoming PCs in program order.
  logic [31:0] exp_q[$];

  // Values observed in the current cycle.
  logic        o_valid, o_hs;
  logic [31:0] o_pc, o_instr, o_addr;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .ADDR_W(32), .RESET_PC(RST_PC), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc)
  );

  // Memory contents: the three program words, otherwise a bijective hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2401_0005;
      32'h4:   return 32'h2422_000A;
      32'h8:   return 32'h0022_1820;
      default: return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endcase
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  // Scoreboard maintenance (no checking here).
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic sb_advance();
    logic [31:0] last;
    last = exp_q[$];
    void'(exp_q.pop_front());
    exp_q.push_back(last + 32'd4);
  endtask

  task automatic model_update();
    if (redirect_valid) sb_restart({redirect_pc[31:2], 2'b00});
    else if (o_hs) sb_advance();
  endtask

  // Drive one cycle's inputs after the falling edge and sample outputs.
  task automatic cycle(input logic en, input logic rdy, input logic rv,
                       input logic [31:0] rpc);
    @(negedge clk);
    fetch_en = en; fetch_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    o_valid = fetch_valid; o_pc = fetch_pc; o_instr = fetch_instr;
    o_addr = imem_addr; o_hs = fetch_valid && fetch_ready;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", fetch_valid);
    end
    n_tests++;
    if (imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC);
    end
    n_tests++;
    if (fetch_pc !== RST_PC) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", fetch_pc, RST_PC);
    end
    n_tests++;
    if (fetch_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr: got %h expected 0", fetch_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_restart(RST_PC);
  endtask

  task automatic test_startup();
    logic [31:0] golden [3];
    golden[0] = 32'h2401_0005; golden[1] = 32'h2422_000A; golden[2] = 32'h0022_1820;
    cycle(1'b1, 1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL startup_first_cycle: got valid=%b expected 0", o_valid);
    end
    model_update();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      n_tests++;
      if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_instr !== golden[k]) begin
        n_fail++;
        $display("FAIL startup_word%0d: got valid=%b pc=%h instr=%h expected 1 %h %h",
                 k, o_valid, o_pc, o_instr, 32'(4 * k), golden[k]);
      end
      model_update();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (o_hs) begin
        n_tests++;
        if (o_pc !== exp_q[0] || o_instr !== mem_word(exp_q[0])) begin
          n_fail++;
          $display("FAIL bp_stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   o_pc, o_instr, exp_q[0], mem_word(exp_q[0]));
        end
      end
      model_update();
    end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      if (c >= 1) begin
        n_tests++;
        if (o_valid !== 1'b1 || o_pc !== exp_q[0] || o_addr !== exp_q[0] + 32'd8) begin
          n_fail++;
          $display("FAIL bp_stall: got valid=%b pc=%h addr=%h expected 1 %h %h",
                   o_valid, o_pc, o_addr, exp_q[0], exp_q[0] + 32'd8);
        end
      end
      model_update();
    end
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (o_hs) begin
        n_tests++;
        if (o_pc !== exp_q[0] || o_instr !== mem_word(exp_q[0])) begin
          n_fail++;
          $display("FAIL bp_release: got pc=%h instr=%h expected pc=%h instr=%h",
                   o_pc, o_instr, exp_q[0], mem_word(exp_q[0]));
        end
      end
      model_update();
    end
  endtask

  task automatic test_redirect();
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      model_update();
    end
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0041);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle_n: got valid=%b expected 0", o_valid);
    end
    model_update();
    cycle(1'b1, 1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_cycle_n1: got valid=%b expected 0", o_valid);
    end
    model_update();
    cycle(1'b1, 1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_instr !== mem_word(32'h40)) begin
      n_fail++;
      $display("FAIL redir_target: got valid=%b pc=%h instr=%h expected 1 00000040 %h",
               o_valid, o_pc, o_instr, mem_word(32'h40));
    end
    model_update();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (o_hs) begin
        n_tests++;
        if (o_pc !== exp_q[0] || o_instr !== mem_word(exp_q[0])) begin
          n_fail++;
          $display("FAIL redir_stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   o_pc, o_instr, exp_q[0], mem_word(exp_q[0]));
        end
      end
      model_update();
    end
  endtask

  task automatic test_redirect_full();
    logic [31:0] tgt;
    bit          seen;
    tgt = $urandom;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      model_update();
    end
    cycle(1'b1, 1'b1, 1'b1, tgt);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_full_hs: got valid=%b expected 0", o_valid);
    end
    model_update();
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (o_hs) begin
        seen = 1'b1;
        n_tests++;
        if (o_pc !== {tgt[31:2], 2'b00} || o_instr !== mem_word({tgt[31:2], 2'b00})) begin
          n_fail++;
          $display("FAIL redir_full_target: got pc=%h instr=%h expected pc=%h",
                   o_pc, o_instr, {tgt[31:2], 2'b00});
        end
      end
      model_update();
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL redir_full_timeout: got no handshake expected pc=%h", {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    int          got;
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    model_update();
    got = 0;
    for (int c = 0; c < 8 && got < 3; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (o_hs) begin
        n_tests++;
        if (o_pc !== want[got] || o_instr !== mem_word(want[got])) begin
          n_fail++;
          $display("FAIL wrap_word%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                   got, o_pc, o_instr, want[got], mem_word(want[got]));
        end
        got++;
      end
      model_update();
    end
    if (got < 3) begin
      n_tests++; n_fail++;
      $display("FAIL wrap_timeout: got %0d words expected 3", got);
    end
  endtask

  task automatic test_fetch_disable();
    logic [31:0] held_addr;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      model_update();
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b1 || o_pc !== exp_q[0] || o_instr !== mem_word(exp_q[0])) begin
      n_fail++;
      $display("FAIL disable_drain: got valid=%b pc=%h expected 1 %h", o_valid, o_pc, exp_q[0]);
    end
    model_update();
    held_addr = o_addr;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      n_tests++;
      if (o_valid !== 1'b0 || o_addr !== held_addr) begin
        n_fail++;
        $display("FAIL disable_idle: got valid=%b addr=%h expected 0 %h", o_valid, o_addr, held_addr);
      end
      model_update();
    end
  endtask

  task automatic test_random();
    logic        en, rdy, rv;
    logic [31:0] rpc;
    int          n_hs;
    n_hs = 0;
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      cycle(en, rdy, rv, rpc);
      if (rv) begin
        n_tests++;
        if (o_valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_redirect_valid: got valid=%b expected 0", o_valid);
        end
      end else if (o_hs) begin
        n_hs++;
        n_tests++;
        if (o_pc !== exp_q[0] || o_instr !== mem_word(exp_q[0])) begin
          n_fail++;
          $display("FAIL rand_stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   o_pc, o_instr, exp_q[0], mem_word(exp_q[0]));
        end
      end
      model_update();
    end
    n_tests++;
    if (n_hs < 50) begin
      n_fail++; $display("FAIL rand_progress: got %0d handshakes expected at least 50", n_hs);
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      model_update();
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      model_update();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (fetch_valid !== 1'b0 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b addr=%h expected 0 %h", fetch_valid, imem_addr, RST_PC);
    end
    fetch_en = 1'b0; fetch_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_restart(RST_PC);
    cycle(1'b1, 1'b1, 1'b0, '0);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_release_quiet: got valid=%b expected 0", o_valid);
    end
    model_update();
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      n_tests++;
      if (o_valid !== 1'b1 || o_pc !== exp_q[0] || o_instr !== mem_word(exp_q[0])) begin
        n_fail++;
        $display("FAIL async_restart: got valid=%b pc=%h instr=%h expected 1 %h %h",
                 o_valid, o_pc, o_instr, exp_q[0], mem_word(exp_q[0]));
      end
      model_update();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_fetch_disable();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
